// File: rtl/regs_port_arbiter.sv
// Shares the register file's two read ports and one write port between the decode stage and the debug unit.
// Optional REGS_ZERO_REG_EN: r0 reads as zero and writes to r0 are acknowledged but dropped.
module regs_port_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int WR_STARVE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      rd_req_valid,
  output logic [1:0]      rd_req_ready,
  input  logic [2*AW-1:0] rd_req_addr1,
  input  logic [2*AW-1:0] rd_req_addr2,
  output logic            rsp_valid,
  output logic            rsp_id,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data1,
  output logic [DW-1:0]   rsp_data2,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  input  logic            dbg_wr_valid,
  output logic            dbg_wr_ready,
  input  logic [AW-1:0]   dbg_wr_addr,
  input  logic [DW-1:0]   dbg_wr_data,
  output logic [AW-1:0]   read_reg1,
  output logic [AW-1:0]   read_reg2,
  output logic            read_en1,
  output logic            read_en2,
  input  logic [DW-1:0]   read_data1_o,
  input  logic [DW-1:0]   read_data2_o,
  output logic [AW-1:0]   write_reg,
  output logic [DW-1:0]   write_data,
  output logic            write_en
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic [7:0]    starve_cnt;
  logic          zero1, zero2;
  logic          issue, gnt;
  logic [AW-1:0] addr1_g, addr2_g;
  logic          dbg_pri, dbg_win, wb_win;

  // A new read may only issue when the response slot is empty or being consumed this cycle.
  assign issue   = !rst && (state == IDLE || rsp_ready) && (|rd_req_valid);
  assign gnt     = (&rd_req_valid) ? ~last_grant : rd_req_valid[1];
  assign addr1_g = gnt ? rd_req_addr1[2*AW-1:AW] : rd_req_addr1[AW-1:0];
  assign addr2_g = gnt ? rd_req_addr2[2*AW-1:AW] : rd_req_addr2[AW-1:0];

  assign rd_req_ready = issue ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign read_reg1    = issue ? addr1_g : '0;
  assign read_reg2    = issue ? addr2_g : '0;
  assign read_en1     = issue;
  assign read_en2     = issue;

  // With read_en low during a stall the register file holds its outputs, so the response stays stable.
  assign rsp_valid = (state == RESP);
  assign rsp_data1 = (rsp_valid && !zero1) ? read_data1_o : '0;
  assign rsp_data2 = (rsp_valid && !zero2) ? read_data2_o : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
    end else if (issue) begin
      state      <= RESP;
      last_grant <= gnt;
      rsp_id     <= gnt;
    end else if (state == RESP && rsp_ready) begin
      state      <= IDLE;
    end
  end

`ifdef REGS_ZERO_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      zero1 <= 1'b0;
      zero2 <= 1'b0;
    end else if (issue) begin
      zero1 <= (addr1_g == '0);
      zero2 <= (addr2_g == '0);
    end
  end
`else
  assign zero1 = 1'b0;
  assign zero2 = 1'b0;
`endif

  // Writeback normally wins; a debug write denied WR_STARVE cycles in a row takes priority once.
  assign dbg_pri = (starve_cnt == 8'(WR_STARVE));
  assign dbg_win = !rst && dbg_wr_valid && (dbg_pri || !wb_valid);
  assign wb_win  = !rst && wb_valid && !dbg_win;

  assign wb_ready     = wb_win;
  assign dbg_wr_ready = dbg_win;
  assign write_reg    = dbg_win ? dbg_wr_addr : (wb_win ? wb_addr : '0);
  assign write_data   = dbg_win ? dbg_wr_data : (wb_win ? wb_data : '0);

`ifdef REGS_ZERO_REG_EN
  assign write_en = (wb_win || dbg_win) && (write_reg != '0);
`else
  assign write_en = wb_win || dbg_win;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!dbg_wr_valid || dbg_win)
      starve_cnt <= '0;
    else if (!dbg_pri)
      starve_cnt <= starve_cnt + 8'd1;
  end
endmodule

// File: tb/tb_regs_port_arbiter.sv
// Bench for regs_port_arbiter: register-file model, directed sequences, then random traffic against a reference model.
module tb_regs_port_arbiter;
  localparam int AW = 5, DW = 32, WS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      rd_req_valid, rd_req_ready;
  logic [2*AW-1:0] rd_req_addr1, rd_req_addr2;
  logic            rsp_valid, rsp_id, rsp_ready;
  logic [DW-1:0]   rsp_data1, rsp_data2;
  logic            wb_valid, wb_ready, dbg_wr_valid, dbg_wr_ready;
  logic [AW-1:0]   wb_addr, dbg_wr_addr;
  logic [DW-1:0]   wb_data, dbg_wr_data;
  logic [AW-1:0]   read_reg1, read_reg2, write_reg;
  logic            read_en1, read_en2, write_en;
  logic [DW-1:0]   read_data1_o = '0, read_data2_o = '0;
  logic [DW-1:0]   write_data;

  regs_port_arbiter #(.AW(AW), .DW(DW), .WR_STARVE(WS)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr1(rd_req_addr1), .rd_req_addr2(rd_req_addr2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
    .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_en1(read_en1), .read_en2(read_en2),
    .read_data1_o(read_data1_o), .read_data2_o(read_data2_o),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en)
  );

  always #5 clk = ~clk;

  // Register file: writes commit on negedge, reads captured on posedge.
  logic [DW-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge clk) if (write_en) rf[write_reg] <= write_data;
  always @(posedge clk) begin
    if (read_en1) read_data1_o <= rf[read_reg1];
    if (read_en2) read_data2_o <= rf[read_reg2];
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] shadow [32];
  bit            m_busy, m_last, m_id;
  int            m_starve;
  logic [DW-1:0] m_d1, m_d2;
  initial for (int i = 0; i < 32; i++) shadow[i] = '0;

  function automatic logic [DW-1:0] rd_shadow(input logic [AW-1:0] a);
`ifdef REGS_ZERO_REG_EN
    if (a == 0) return '0;
`endif
    return shadow[a];
  endfunction

  task automatic model_check();
    bit req, g, dw, we;
    logic [AW-1:0] a1, a2, wa;
    logic [DW-1:0] wd;
    if (rst) begin
      chk("rst_write_en", write_en, 0);
      chk("rst_wb_ready", wb_ready, 0);
      chk("rst_dbg_ready", dbg_wr_ready, 0);
      chk("rst_rd_ready", rd_req_ready, 0);
      m_busy = 0; m_last = 1; m_starve = 0;
      return;
    end
    chk("rsp_valid", rsp_valid, m_busy);
    if (m_busy) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data1", rsp_data1, m_d1);
      chk("rsp_data2", rsp_data2, m_d2);
    end
    req = (rd_req_valid != 0) && (!m_busy || rsp_ready);
    g   = (rd_req_valid == 2'b11) ? !m_last : rd_req_valid[1];
    a1  = g ? rd_req_addr1[2*AW-1:AW] : rd_req_addr1[AW-1:0];
    a2  = g ? rd_req_addr2[2*AW-1:AW] : rd_req_addr2[AW-1:0];
    chk("rd_req_ready", rd_req_ready, req ? (g ? 2'b10 : 2'b01) : 2'b00);
    chk("read_en1", read_en1, req);
    chk("read_en2", read_en2, req);
    if (req) begin
      chk("read_reg1", read_reg1, a1);
      chk("read_reg2", read_reg2, a2);
    end
    dw = dbg_wr_valid && (m_starve >= WS || !wb_valid);
    chk("wb_ready", wb_ready, wb_valid && !dw);
    chk("dbg_wr_ready", dbg_wr_ready, dw);
    wa = dw ? dbg_wr_addr : wb_addr;
    wd = dw ? dbg_wr_data : wb_data;
    we = wb_valid || dbg_wr_valid;
`ifdef REGS_ZERO_REG_EN
    if (wa == 0) we = 0;
`endif
    chk("write_en", write_en, we);
    if (we) begin
      chk("write_reg", write_reg, wa);
      chk("write_data", write_data, wd);
      shadow[wa] = wd;
    end
    if (req) begin
      m_busy = 1; m_id = g; m_last = g;
      m_d1 = rd_shadow(a1); m_d2 = rd_shadow(a2);
    end else if (m_busy && rsp_ready) m_busy = 0;
    if (dbg_wr_valid && !dw) m_starve = (m_starve < WS) ? m_starve + 1 : WS;
    else m_starve = 0;
  endtask

  task automatic settle(); #3; endtask
  task automatic adv(); model_check(); @(posedge clk); #1; endtask
  task automatic step(); settle(); adv(); endtask

  task automatic idle_inputs();
    rst = 0; rd_req_valid = 0; rd_req_addr1 = 0; rd_req_addr2 = 0; rsp_ready = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; dbg_wr_valid = 0; dbg_wr_addr = 0; dbg_wr_data = 0;
  endtask

  typedef struct {
    logic wbv, dbv; logic [AW-1:0] wa, da; logic [DW-1:0] wd, dd;
    logic e_wbr, e_dbr, e_we; logic [AW-1:0] e_reg; logic [DW-1:0] e_data;
  } wvec_t;
  wvec_t wv [5];

  initial begin
    wv[0] = '{0, 0, 5'd0, 5'd0, 32'h0,  32'h0,  0, 0, 0, 5'd0,  32'h0};
    wv[1] = '{1, 0, 5'd3, 5'd0, 32'h11, 32'h0,  1, 0, 1, 5'd3,  32'h11};
    wv[2] = '{0, 1, 5'd0, 5'd7, 32'h0,  32'h22, 0, 1, 1, 5'd7,  32'h22};
    wv[3] = '{1, 1, 5'd9, 5'd10,32'h99, 32'haa, 1, 0, 1, 5'd9,  32'h99};
    wv[4] = '{0, 0, 5'd0, 5'd0, 32'h0,  32'h0,  0, 0, 0, 5'd0,  32'h0};

    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    step();
    settle();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rd_ready", rd_req_ready, 0);
    chk("reset_write_en", write_en, 0);
    rst = 0;
    adv();

    // Write arbitration table; rows 1-2 preload r3=0x11, r7=0x22.
    for (int i = 0; i < 5; i++) begin
      wb_valid = wv[i].wbv; dbg_wr_valid = wv[i].dbv;
      wb_addr = wv[i].wa; dbg_wr_addr = wv[i].da; wb_data = wv[i].wd; dbg_wr_data = wv[i].dd;
      settle();
      chk($sformatf("tbl%0d_wb_ready", i), wb_ready, wv[i].e_wbr);
      chk($sformatf("tbl%0d_dbg_ready", i), dbg_wr_ready, wv[i].e_dbr);
      chk($sformatf("tbl%0d_write_en", i), write_en, wv[i].e_we);
      if (wv[i].e_we) begin
        chk($sformatf("tbl%0d_write_reg", i), write_reg, wv[i].e_reg);
        chk($sformatf("tbl%0d_write_data", i), write_data, wv[i].e_data);
      end
      adv();
    end
    idle_inputs();

    // Single read of (3,7) by requester 0
    rd_req_valid = 2'b01; rd_req_addr1 = {5'd0, 5'd3}; rd_req_addr2 = {5'd0, 5'd7};
    settle();
    chk("single_rd_ready", rd_req_ready, 2'b01);
    adv();
    rd_req_valid = 0; rsp_ready = 1;
    settle();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 0);
    chk("single_data1", rsp_data1, 32'h11);
    chk("single_data2", rsp_data2, 32'h22);
    adv();

    // Round robin from a fresh reset: grants 0,1,0,1
    idle_inputs(); rst = 1; step(); rst = 0;
    rd_req_valid = 2'b11; rsp_ready = 1;
    rd_req_addr1 = {5'd3, 5'd3}; rd_req_addr2 = {5'd7, 5'd7};
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("rr%0d_grant", i), rd_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk($sformatf("rr%0d_rsp_id", i), rsp_id, (i % 2 == 0) ? 1'b1 : 1'b0);
      adv();
    end
    rd_req_valid = 0;
    step();

    // Backpressure: requester 0 reads r3, response stalled for 3 cycles
    rd_req_valid = 2'b01; rsp_ready = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp%0d_rd_ready", i), rd_req_ready, 0);
      chk($sformatf("bp%0d_read_en1", i), read_en1, 0);
      chk($sformatf("bp%0d_data1", i), rsp_data1, 32'h11);
      adv();
    end
    rsp_ready = 1;
    settle();
    chk("bp_release_grant", rd_req_ready, 2'b01);
    adv();
    rd_req_valid = 0;
    step();

    // Same-cycle write and read of r5
    wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hABCD;
    rd_req_valid = 2'b01; rd_req_addr1 = {5'd0, 5'd5}; rd_req_addr2 = {5'd0, 5'd5};
    step();
    wb_valid = 0; rd_req_valid = 0;
    settle();
    chk("same_cycle_data1", rsp_data1, 32'hABCD);
    adv();
    step();

    // Starvation: debug denied WS cycles, then wins once
    wb_valid = 1; wb_addr = 5'd12; wb_data = 32'h1;
    dbg_wr_valid = 1; dbg_wr_addr = 5'd13; dbg_wr_data = 32'h2;
    for (int i = 0; i < WS; i++) begin
      settle();
      chk($sformatf("starve%0d_dbg_ready", i), dbg_wr_ready, 0);
      adv();
    end
    settle();
    chk("starve_win_dbg_ready", dbg_wr_ready, 1);
    chk("starve_win_wb_ready", wb_ready, 0);
    adv();
    settle();
    chk("starve_after_wb_ready", wb_ready, 1);
    adv();
    idle_inputs();
    step();

`ifdef REGS_ZERO_REG_EN
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    settle();
    chk("zero_wb_ready", wb_ready, 1);
    chk("zero_write_en", write_en, 0);
    adv();
    wb_valid = 0; rd_req_valid = 2'b10; rd_req_addr1 = '0; rd_req_addr2 = '0;
    step();
    rd_req_valid = 0; rsp_ready = 1;
    settle();
    chk("zero_rsp_data1", rsp_data1, 0);
    adv();
    idle_inputs();
    step();
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(99) == 0);
      rd_req_valid = 2'($urandom);
      rd_req_addr1 = 10'($urandom);
      rd_req_addr2 = 10'($urandom);
      rsp_ready    = ($urandom_range(3) != 0);
      wb_valid     = ($urandom_range(2) != 0);
      wb_addr      = 5'($urandom);
      wb_data      = $urandom;
      dbg_wr_valid = ($urandom_range(1) != 0);
      dbg_wr_addr  = 5'($urandom);
      dbg_wr_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
